// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encodings and default byte width.
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module uart_tx_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    int jj;
    logic [PW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    jj    = 0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      jj = (int'(ptr_i) + k) % N;
      j  = PW'(jj);
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = j;
        vld_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between N_REQ byte producers with per-message
// round-robin arbitration and a start/done handshake toward the serializer.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_d_out,
  input  logic                    tx_done,
  output logic                    busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic              lock_q, lock_d;
  logic              tx_start_q, tx_start_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] tx_d_q, tx_d_d;

  logic [N_REQ-1:0]  elig, pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_vld, owner_req;

  // While a message is open only its owner may win; if the owner drops req
  // the lock is abandoned and everyone competes again in the same cycle.
  assign owner_req = req[owner_q];
  assign elig      = (lock_q && owner_req) ? (N_REQ'(1) << owner_q) : req;

  uart_tx_arbiter_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req_i (elig),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    tx_start_d = tx_start_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_d_d     = tx_d_q;
    case (state_q)
      ST_IDLE: begin
        if (lock_q && !owner_req) begin
          lock_d  = 1'b0;
          grant_d = '0;
        end
        if (pick_vld) begin
          owner_d    = pick_idx;
          grant_d    = pick_gnt;
          lock_d     = ~last[pick_idx];
          tx_d_d     = data[pick_idx*DATA_W +: DATA_W];
          tx_start_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          tx_start_d     = 1'b0;
          ack_d[owner_q] = 1'b1;
          state_d        = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Waiting for done to fall keeps a stale done from ending the next frame.
        if (!tx_done) begin
          state_d = ST_IDLE;
          if (!lock_q) begin
            grant_d = '0;
            rr_d    = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      tx_start_q <= 1'b0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_d_q     <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      tx_start_q <= tx_start_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_d_q     <= tx_d_d;
    end
  end

  assign ack      = ack_q;
  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_d_out = tx_d_q;
  assign busy     = (state_q != ST_IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: serializer responder, queue-based requesters,
// an arbitration model checked every cycle, and directed literal expectations.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   req, last;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack, grant;
  logic           tx_start;
  logic [W-1:0]   tx_d_out;
  logic           tx_done = 1'b0;
  logic           busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .last     (last),
    .data     (data),
    .ack      (ack),
    .grant    (grant),
    .tx_start (tx_start),
    .tx_d_out (tx_d_out),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  // Serializer stand-in: done rises LAT cycles into a frame, falls after start drops.
  int ucnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      ucnt    <= 0;
      tx_done <= 1'b0;
    end else if (tx_start && !tx_done) begin
      if (ucnt == LAT) tx_done <= 1'b1;
      else             ucnt    <= ucnt + 1;
    end else if (!tx_start) begin
      ucnt    <= 0;
      tx_done <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       l;
  } item_t;

  item_t      rq[N][$];
  logic [7:0] rxq[$];
  int         ack_cnt[N];
  int         errors = 0;
  int         checks = 0;

  // Abstract arbitration model: pending set, open-message owner, next-start pointer.
  int         m_rr = 0;
  int         m_lock = -1;
  int         cur_owner = -1;
  logic [N-1:0] p_req = '0;
  logic [N-1:0] p_ack = '0;
  logic       p_start = 1'b0, p_done = 1'b0, p_rst = 1'b1;
  logic [7:0] p_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] pend);
    if (m_lock >= 0 && pend[m_lock]) return m_lock;
    m_lock = -1;
    for (int k = 0; k < N; k++)
      if (pend[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst && !p_rst) begin
      chk("ack_onehot", 64'($countones(ack) <= 1), 64'd1);
      chk("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
      if (tx_start && !p_start) begin
        int e;
        chk("start_while_done", 64'(p_done), 64'd0);
        e = model_pick(p_req);
        checks++;
        if (e < 0 || rq[e].size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got start with grant %0h expected no start", grant);
        end else begin
          chk("grant_owner", 64'(grant), 64'(1 << e));
          chk("start_byte", 64'(tx_d_out), 64'(rq[e][0].d));
          if (rq[e][0].l) begin
            m_lock = -1;
            m_rr   = (e + 1) % N;
          end else begin
            m_lock = e;
          end
          cur_owner = e;
        end
      end
      if (tx_start && p_start) chk("d_stable", 64'(tx_d_out), 64'(p_d));
      if (ack != '0) begin
        chk("ack_owner", 64'(ack), (cur_owner >= 0) ? 64'(1 << cur_owner) : 64'd0);
        chk("ack_width", 64'(p_ack), 64'd0);
        chk("ack_after_done", 64'({p_start, p_done}), 64'd3);
        rxq.push_back(tx_d_out);
        if (cur_owner >= 0) ack_cnt[cur_owner]++;
      end
      if (!busy) chk("idle_quiet", 64'({grant, tx_start}), 64'd0);
    end
    // Requesters: pop on ack, then present the current head.
    for (int i = 0; i < N; i++)
      if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !rst) begin
        req[i]        = 1'b1;
        last[i]       = rq[i][0].l;
        data[i*W +: W] = rq[i][0].d;
      end else begin
        req[i]        = 1'b0;
        last[i]       = 1'b0;
        data[i*W +: W] = '0;
      end
    end
    p_req   = req;
    p_ack   = ack;
    p_start = tx_start;
    p_done  = tx_done;
    p_d     = tx_d_out;
    p_rst   = rst;
  end

  task automatic push(input int i, input logic [7:0] d, input logic l);
    item_t it;
    it.d = d;
    it.l = l;
    rq[i].push_back(it);
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 2000 && (pending() || busy || tx_start || tx_done)) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got still busy expected idle within 2000 cycles", name);
    end
  endtask

  task automatic chk_rx(input string name, input int n, input logic [63:0] exp);
    logic [63:0] act = '0;
    chk({name, "_count"}, 64'(rxq.size()), 64'(n));
    foreach (rxq[i]) act = {act[55:0], rxq[i]};
    chk(name, act, exp);
    rxq.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    m_rr = 0; m_lock = -1; cur_owner = -1;
    @(posedge clk); #1;
  endtask

  initial begin
    int a2;
    req = '0; last = '0; data = '0;
    foreach (ack_cnt[i]) ack_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_tx_d_out", 64'(tx_d_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte, start latency of one cycle after req is seen.
    push(0, 8'h68, 1'b1);
    @(negedge clk);
    chk("t1_no_early_start", 64'(tx_start), 64'd0);
    @(posedge clk); #1;
    chk("t1_start_latency", 64'(tx_start), 64'd1);
    chk("t1_grant", 64'(grant), 64'h1);
    wait_idle("t1");
    chk_rx("t1_rx", 1, 64'h68);
    chk("t1_acks", 64'(ack_cnt[0]), 64'd1);
    chk("t1_grant_idle", 64'(grant), 64'd0);
    chk("t1_busy_idle", 64'(busy), 64'd0);

    // Four simultaneous single-byte messages, twice, from a fresh pointer.
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    wait_idle("t2a");
    chk_rx("t2_rx_round1", 4, 64'hA0A1A2A3);
    for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    wait_idle("t2b");
    chk_rx("t2_rx_round2", 4, 64'hA0A1A2A3);

    // Locked message beats a waiting competitor.
    push(0, 8'h68, 1'b0); push(0, 8'h65, 1'b0); push(0, 8'h6C, 1'b0);
    push(0, 8'h6C, 1'b0); push(0, 8'h6F, 1'b1);
    push(1, 8'h55, 1'b1);
    wait_idle("t3");
    chk_rx("t3_rx", 6, 64'h68656C6C6F55);

    // Owner abandons after a last=0 byte; lock released for requester 1.
    a2 = ack_cnt[0];
    push(0, 8'h68, 1'b0);
    push(1, 8'h55, 1'b1);
    wait_idle("t4");
    chk_rx("t4_rx", 2, 64'h6855);
    chk("t4_acks_req0", 64'(ack_cnt[0] - a2), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_grant", 64'(grant), 64'd0);

    // Reset in the middle of a frame.
    push(2, 8'h3C, 1'b1);
    begin
      int n = 0;
      while (n < 50 && !tx_start) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL t5_start_timeout: got no start expected start within 50 cycles");
      end
    end
    @(posedge clk); #1;
    a2  = ack_cnt[2];
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    m_rr = 0; m_lock = -1; cur_owner = -1;
    @(posedge clk); #1;
    chk("t5_start_dropped", 64'(tx_start), 64'd0);
    chk("t5_grant", 64'(grant), 64'd0);
    chk("t5_ack", 64'(ack), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("t5_no_ack", 64'(ack_cnt[2] - a2), 64'd0);
    chk("t5_no_rx", 64'(rxq.size()), 64'd0);
    push(3, 8'h7E, 1'b1);
    wait_idle("t5");
    chk_rx("t5_rx_after", 1, 64'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
